// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package if_id_queue_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_INST_W = 32;

  localparam logic [DEFAULT_ADDR_W-1:0] ZeroWord = '0;
  localparam logic [DEFAULT_INST_W-1:0] ZeroInst = '0;

  // One queued fetch result; pred_taken is only carried when prediction is enabled.
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [DEFAULT_INST_W-1:0] inst;
    logic                      pred_taken;
  } entry_t;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: circular buffer of fetched {pc, inst} entries feeding decode.
// Define IF_ID_QUEUE_PRED_EN to carry a per-entry predicted-taken bit (in/out_pred_taken).
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned INST_W = DEFAULT_INST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [INST_W-1:0]      in_inst,
`ifdef IF_ID_QUEUE_PRED_EN
  input  logic                   in_pred_taken,
  output logic                   out_pred_taken,
`endif
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INST_W-1:0]      out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
`ifdef IF_ID_QUEUE_PRED_EN
  logic              pred_mem_q [DEPTH];
`endif
  logic              push;
  logic              pop;

  assign count     = count_q;
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[head_q]   : ADDR_W'(ZeroWord);
  assign out_inst  = out_valid ? inst_mem_q[head_q] : INST_W'(ZeroInst);
`ifdef IF_ID_QUEUE_PRED_EN
  assign out_pred_taken = out_valid ? pred_mem_q[head_q] : 1'b0;
`endif

  // Flush and a low rdy both suppress every transfer; flush then clears the queue.
  always_comb begin
    push    = in_valid && in_ready && rdy && !flush;
    pop     = out_valid && out_ready && rdy && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; only occupied slots are ever read out.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[tail_q]   <= in_pc;
      inst_mem_q[tail_q] <= in_inst;
`ifdef IF_ID_QUEUE_PRED_EN
      pred_mem_q[tail_q] <= in_pred_taken;
`endif
    end
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter INST_W, default 32, instruction width.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rdy  input  1  global ready; low freezes all state.
REQ-007 flush  input  1  branch mispredict from EX; discards all entries.
REQ-008 in_valid  input  1  fetch presents an entry.
REQ-009 in_pc  input  ADDR_W  fetched PC.
REQ-010 in_inst  input  INST_W  fetched instruction.
REQ-011 in_ready  output  1  queue accepts an entry this cycle.
REQ-012 out_valid  output  1  head entry available to decode.
REQ-013 out_ready  input  1  decode consumes the head entry (not stalled).
REQ-014 out_pc  output  ADDR_W  head PC; zero when empty.
REQ-015 out_inst  output  INST_W  head instruction; zero (bubble) when empty.
REQ-016 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Circular buffer of DEPTH {pc, inst} entries, with head and tail pointers wrapping modulo DEPTH.
REQ-018 in_ready = (count < DEPTH); there is no same-cycle pass-through when the queue is full.
REQ-019 A push occurs when in_valid && in_ready && rdy && !flush; it writes at tail, and tail increments.
REQ-020 A pop occurs when out_valid && out_ready && rdy && !flush; head increments.
REQ-021 Simultaneous push and pop leave count unchanged, and both pointers advance.
REQ-022 Push-to-output latency is 1 cycle: an entry pushed into an empty queue is visible on out_* the next cycle.
REQ-023 out_valid = (count != 0); out_pc/out_inst read the head entry combinationally when valid, otherwise they are zero.
REQ-024 Entry order is strictly preserved FIFO; no entry is dropped or duplicated except by flush.
REQ-025 Flush with rdy high zeroes count, head, and tail next cycle. Flush has priority over any push and pop in the same cycle.
REQ-026 With rdy low: no push, no pop, no flush, and no pointer/count change. Outputs keep reflecting the held state.
REQ-027 An in_valid while full is not accepted; the source holds it until in_ready.
REQ-028 out_ready while empty has no effect.

Reset
REQ-029 rst has priority over rdy and flush.
REQ-030 rst zeroes count, head, and tail, so out_valid=0, out_pc=0, out_inst=0, in_ready=1 next cycle.
REQ-031 Entry storage contents need no reset.
REQ-032 Reset mid-operation discards all entries.

Configuration
REQ-033 With IF_ID_QUEUE_PRED_EN defined:
- adds input in_pred_taken (1) and output out_pred_taken (1);
- the prediction bit is stored per entry and follows the FIFO/flush rules;
- out_pred_taken is 0 when empty or after reset.
REQ-034 Without IF_ID_QUEUE_PRED_EN, those ports and storage do not exist; the block is otherwise identical.

Structure
REQ-035 Shared package holds:
- ZeroWord/ZeroInst constants;
- default ADDR_W/INST_W;
- the entry struct typedef {pc, inst, pred_taken}.
REQ-036 The block is a single module with no sub-module; pointer/count logic is inline.

Verification (DEPTH=4)
REQ-037 Reset, then push pc=0x100, inst=0x00000013 -> next cycle out_valid=1, out_pc=0x100, count=1.
REQ-038 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th push is refused; popping yields 0x100, 0x104, 0x108, 0x10C in order.
REQ-039 Full queue with simultaneous in_valid and out_ready, rdy=1 -> only the pop occurs (count 4->3); steady push+pop at count=2 holds count=2 across pointer wrap.
REQ-040 Flush asserted together with push and pop at count=3 -> next cycle count=0, out_pc=0, out_inst=0, in_ready=1.
REQ-041 rdy=0 for 3 cycles with in_valid, out_ready, and flush all high -> count, out_pc, and out_inst unchanged.
REQ-042 With IF_ID_QUEUE_PRED_EN: push pred bits 1,0,1 -> pops emit out_pred_taken 1,0,1; after flush, out_pred_taken=0.
